// File: rtl/sentinel_key_presenter.sv
// sentinel_key_presenter
// Initiator-side driver for the Sentinel lock gate. It takes a key over a
// valid/ready request, drives the key onto the gate's key lines, and waits
// for the gate outputs to settle. It then requires CONFIRM_SAMPLES identical
// {seg, glow} samples before it decodes them into LOCKED / VERIFIED /
// BRICKED / FAULT. The result goes back over a valid/ready response.
// Optional build macro SENTINEL_PRESENTER_SWEEP_EN adds an autonomous key
// sweep (0x00..0xFF) that stops on the first VERIFIED key.
// All outputs are driven straight from flops. Reset is asynchronous, active-high.

module sentinel_key_presenter #(
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned CONFIRM_SAMPLES = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [7:0] req_key,
    output logic       req_ready,
    output logic [7:0] key_out,
    input  logic [7:0] seg_in,
    input  logic [7:0] glow_in,
    output logic       rsp_valid,
    output logic [1:0] rsp_result,
    output logic [7:0] rsp_seg,
    input  logic       rsp_ready,
`ifdef SENTINEL_PRESENTER_SWEEP_EN
    input  logic       sweep_start,
    output logic       sweep_done,
    output logic       sweep_found,
    output logic [7:0] found_key,
`endif
    output logic       busy
);

    // Result encoding seen by the consumer.
    localparam logic [1:0] RES_LOCKED   = 2'b00;
    localparam logic [1:0] RES_VERIFIED = 2'b01;
    localparam logic [1:0] RES_BRICKED  = 2'b10;
    localparam logic [1:0] RES_FAULT    = 2'b11;

    // Terminal counter values, sized to each counter.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] CONFIRM_N   = 4'(CONFIRM_SAMPLES);
    localparam logic [9:0] TIMEOUT_N   = 10'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_RESP   = 3'd3,
        ST_BLANK  = 3'd4
    } state_t;

    // Decode one gate snapshot. Any pattern other than the three legal
    // gate states (disabled 0xFF, seg/glow disagreement, glitches) is FAULT.
    function automatic logic [1:0] f_classify(input logic [7:0] seg, input logic [7:0] glow);
        logic [1:0] res;
        if (seg == 8'hC7 && glow == 8'h00) begin
            res = RES_LOCKED;
        end else if (seg == 8'hC1 && glow == 8'hFF) begin
            res = RES_VERIFIED;
        end else if (seg == 8'h00 && glow == 8'h00) begin
            res = RES_BRICKED;
        end else begin
            res = RES_FAULT;
        end
        return res;
    endfunction

    // Registered state and outputs
    state_t      r_state;
    logic [7:0]  r_key;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [1:0]  r_rsp_result;
    logic [7:0]  r_rsp_seg;
    logic        r_busy;
    logic [7:0]  r_settle_cnt;
    logic [3:0]  r_match_cnt;   // 0 means "no previous sample yet"
    logic [9:0]  r_tmo_cnt;
    logic [15:0] r_prev;

    // Next-state values
    state_t      w_state_nxt;
    logic [7:0]  w_key_nxt;
    logic        w_req_ready_nxt;
    logic        w_rsp_valid_nxt;
    logic [1:0]  w_rsp_result_nxt;
    logic [7:0]  w_rsp_seg_nxt;
    logic [7:0]  w_settle_cnt_nxt;
    logic [3:0]  w_match_cnt_nxt;
    logic [9:0]  w_tmo_cnt_nxt;
    logic [15:0] w_prev_nxt;

    // Per-cycle sample evaluation
    logic [15:0] w_sample;
    logic [3:0]  w_match_inc;
    logic [9:0]  w_tmo_inc;
    logic        w_confirm;
    logic        w_timeout;
    logic [1:0]  w_fin_res;

`ifdef SENTINEL_PRESENTER_SWEEP_EN
    logic        r_sweep_active;
    logic [7:0]  r_sweep_key;
    logic        r_sweep_done;
    logic        r_sweep_found;
    logic [7:0]  r_found_key;
    logic        w_sweep_active_nxt;
    logic [7:0]  w_sweep_key_nxt;
    logic        w_sweep_done_nxt;
    logic        w_sweep_found_nxt;
    logic [7:0]  w_found_key_nxt;
`endif

    assign w_sample = {seg_in, glow_in};

    // Match and timeout bookkeeping for the current SAMPLE cycle (saturating).
    always_comb begin
        w_match_inc = 4'h1;
        w_tmo_inc   = r_tmo_cnt;
        if (r_match_cnt != 4'h0 && w_sample == r_prev) begin
            w_match_inc = (r_match_cnt == 4'hF) ? 4'hF : (r_match_cnt + 4'h1);
        end else begin
            w_match_inc = 4'h1;
        end
        if (r_tmo_cnt == 10'h3FF) begin
            w_tmo_inc = 10'h3FF;
        end else begin
            w_tmo_inc = r_tmo_cnt + 10'h001;
        end
        w_confirm = (w_match_inc >= CONFIRM_N);
        w_timeout = (w_tmo_inc >= TIMEOUT_N);
        w_fin_res = w_confirm ? f_classify(seg_in, glow_in) : RES_FAULT;
    end

    // Next-state and next-output decode for the presenter FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_key_nxt        = r_key;
        w_req_ready_nxt  = r_req_ready;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_result_nxt = r_rsp_result;
        w_rsp_seg_nxt    = r_rsp_seg;
        w_settle_cnt_nxt = r_settle_cnt;
        w_match_cnt_nxt  = r_match_cnt;
        w_tmo_cnt_nxt    = r_tmo_cnt;
        w_prev_nxt       = r_prev;
`ifdef SENTINEL_PRESENTER_SWEEP_EN
        w_sweep_active_nxt = r_sweep_active;
        w_sweep_key_nxt    = r_sweep_key;
        w_sweep_done_nxt   = r_sweep_done;
        w_sweep_found_nxt  = r_sweep_found;
        w_found_key_nxt    = r_found_key;
`endif

        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_key_nxt        = req_key;
                    w_req_ready_nxt  = 1'b0;
                    w_settle_cnt_nxt = 8'h00;
                    w_state_nxt      = ST_SETTLE;
`ifdef SENTINEL_PRESENTER_SWEEP_EN
                end else if (sweep_start) begin
                    // Sweep starts at key 0x00, which is also the idle key value.
                    w_sweep_active_nxt = 1'b1;
                    w_sweep_key_nxt    = 8'h00;
                    w_sweep_done_nxt   = 1'b0;
                    w_sweep_found_nxt  = 1'b0;
                    w_found_key_nxt    = 8'h00;
                    w_key_nxt          = 8'h00;
                    w_req_ready_nxt    = 1'b0;
                    w_settle_cnt_nxt   = 8'h00;
                    w_state_nxt        = ST_SETTLE;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                if (r_settle_cnt >= SETTLE_LAST) begin
                    w_match_cnt_nxt = 4'h0;
                    w_tmo_cnt_nxt   = 10'h000;
                    w_state_nxt     = ST_SAMPLE;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + 8'h01;
                end
            end

            ST_SAMPLE: begin
                w_prev_nxt      = w_sample;
                w_match_cnt_nxt = w_match_inc;
                w_tmo_cnt_nxt   = w_tmo_inc;
                if (w_confirm || w_timeout) begin
`ifdef SENTINEL_PRESENTER_SWEEP_EN
                    if (r_sweep_active) begin
                        if (w_fin_res == RES_VERIFIED) begin
                            w_found_key_nxt    = r_sweep_key;
                            w_sweep_found_nxt  = 1'b1;
                            w_sweep_done_nxt   = 1'b1;
                            w_sweep_active_nxt = 1'b0;
                            w_key_nxt          = 8'h00;
                            w_req_ready_nxt    = 1'b1;
                            w_state_nxt        = ST_IDLE;
                        end else if (w_fin_res == RES_LOCKED) begin
                            w_key_nxt = 8'h00;
                            if (r_sweep_key == 8'hFF) begin
                                w_sweep_done_nxt   = 1'b1;
                                w_sweep_active_nxt = 1'b0;
                                w_req_ready_nxt    = 1'b1;
                                w_state_nxt        = ST_IDLE;
                            end else begin
                                w_state_nxt = ST_BLANK;
                            end
                        end else begin
                            // BRICKED or FAULT ends the sweep and is reported.
                            w_sweep_done_nxt   = 1'b1;
                            w_sweep_active_nxt = 1'b0;
                            w_rsp_valid_nxt    = 1'b1;
                            w_rsp_result_nxt   = w_fin_res;
                            w_rsp_seg_nxt      = seg_in;
                            w_state_nxt        = ST_RESP;
                        end
                    end else begin
                        w_rsp_valid_nxt  = 1'b1;
                        w_rsp_result_nxt = w_fin_res;
                        w_rsp_seg_nxt    = seg_in;
                        w_state_nxt      = ST_RESP;
                    end
`else
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_result_nxt = w_fin_res;
                    w_rsp_seg_nxt    = seg_in;
                    w_state_nxt      = ST_RESP;
`endif
                end else begin
                    w_state_nxt = ST_SAMPLE;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_key_nxt       = 8'h00;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end

            ST_BLANK: begin
`ifdef SENTINEL_PRESENTER_SWEEP_EN
                // One cycle with key_out at 0x00 separates sweep keys.
                w_sweep_key_nxt  = r_sweep_key + 8'h01;
                w_key_nxt        = r_sweep_key + 8'h01;
                w_settle_cnt_nxt = 8'h00;
                w_state_nxt      = ST_SETTLE;
`else
                w_key_nxt       = 8'h00;
                w_req_ready_nxt = 1'b1;
                w_state_nxt     = ST_IDLE;
`endif
            end

            default: begin
                w_key_nxt       = 8'h00;
                w_req_ready_nxt = 1'b1;
                w_rsp_valid_nxt = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_key        <= 8'h00;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 2'b00;
            r_rsp_seg    <= 8'h00;
            r_busy       <= 1'b0;
            r_settle_cnt <= 8'h00;
            r_match_cnt  <= 4'h0;
            r_tmo_cnt    <= 10'h000;
            r_prev       <= 16'h0000;
        end else begin
            r_state      <= w_state_nxt;
            r_key        <= w_key_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_result <= w_rsp_result_nxt;
            r_rsp_seg    <= w_rsp_seg_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_settle_cnt <= w_settle_cnt_nxt;
            r_match_cnt  <= w_match_cnt_nxt;
            r_tmo_cnt    <= w_tmo_cnt_nxt;
            r_prev       <= w_prev_nxt;
        end
    end

`ifdef SENTINEL_PRESENTER_SWEEP_EN
    // Sweep progress and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sweep_active <= 1'b0;
            r_sweep_key    <= 8'h00;
            r_sweep_done   <= 1'b0;
            r_sweep_found  <= 1'b0;
            r_found_key    <= 8'h00;
        end else begin
            r_sweep_active <= w_sweep_active_nxt;
            r_sweep_key    <= w_sweep_key_nxt;
            r_sweep_done   <= w_sweep_done_nxt;
            r_sweep_found  <= w_sweep_found_nxt;
            r_found_key    <= w_found_key_nxt;
        end
    end

    assign sweep_done  = r_sweep_done;
    assign sweep_found = r_sweep_found;
    assign found_key   = r_found_key;
`endif

    assign req_ready  = r_req_ready;
    assign key_out    = r_key;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_seg    = r_rsp_seg;
    assign busy       = r_busy;

endmodule

// File: tb/tb_sentinel_key_presenter.sv
// Directed testbench for sentinel_key_presenter with a behavioural gate model.
// Build with SENTINEL_PRESENTER_SWEEP_EN defined to also exercise the key sweep.

module tb_sentinel_key_presenter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_key = 8'h00;
    logic       req_ready;
    logic [7:0] key_out;
    logic [7:0] seg_in;
    logic [7:0] glow_in;
    logic       rsp_valid;
    logic [1:0] rsp_result;
    logic [7:0] rsp_seg;
    logic       rsp_ready = 1'b0;
    logic       busy;
`ifdef SENTINEL_PRESENTER_SWEEP_EN
    logic       sweep_start = 1'b0;
    logic       sweep_done;
    logic       sweep_found;
    logic [7:0] found_key;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int gate_mode = 0;
    logic tog = 1'b0;

    sentinel_key_presenter #(
        .SETTLE_CYCLES(4), .CONFIRM_SAMPLES(2), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
        .key_out(key_out), .seg_in(seg_in), .glow_in(glow_in),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_seg(rsp_seg),
        .rsp_ready(rsp_ready),
`ifdef SENTINEL_PRESENTER_SWEEP_EN
        .sweep_start(sweep_start), .sweep_done(sweep_done),
        .sweep_found(sweep_found), .found_key(found_key),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Toggle source for the alternating-gate mode.
    always @(posedge clk) tog <= ~tog;

    // Gate model: 0 locked, 1 unlock on 0xB6, 2 alternating, 3 disabled, 4 bricked, 5 unlock on 0x07
    always_comb begin
        seg_in  = 8'hC7;
        glow_in = 8'h00;
        case (gate_mode)
            1: if (key_out == 8'hB6) begin seg_in = 8'hC1; glow_in = 8'hFF; end
            2: seg_in = tog ? 8'hC7 : 8'hC1;
            3: seg_in = 8'hFF;
            4: seg_in = 8'h00;
            5: if (key_out == 8'h07) begin seg_in = 8'hC1; glow_in = 8'hFF; end
            default: seg_in = 8'hC7;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request; returns after the accepting edge.
    task automatic send(input logic [7:0] k);
        req_key   = k;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Count edges until rsp_valid, bounded.
    task automatic wait_rsp(input int bound, output int n);
        n = 0;
        while (!rsp_valid && n < bound) begin
            tick();
            n++;
        end
        check("rsp_wait", {15'd0, rsp_valid}, 16'd1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_hs", {key_out, 5'd0, rsp_valid, req_ready, busy}, {8'h00, 5'd0, 1'b0, 1'b1, 1'b0});
    endtask

    initial begin
        // Reset values
        tick(); tick();
        check("rst_key", {8'd0, key_out}, 16'h0000);
        check("rst_flags", {13'd0, req_ready, rsp_valid, busy}, 16'h0004);
        check("rst_rsp", {6'd0, rsp_result, rsp_seg}, 16'h0000);
        rst = 1'b0;
        tick();

        // Locked gate, key 0x5A: rsp_valid on the 7th edge counting the accept edge
        gate_mode = 0;
        send(8'h5A);
        check("t1_key", {8'd0, key_out}, 16'h005A);
        check("t1_busy", {14'd0, req_ready, busy}, 16'h0001);
        for (int i = 0; i < 5; i++) tick();
        check("t1_not_yet", {15'd0, rsp_valid}, 16'd0);
        tick();
        check("t1_rsp", {5'd0, rsp_valid, rsp_result, rsp_seg}, {5'd0, 1'b1, 2'b00, 8'hC7});
        handshake();

        // Unlocking gate on 0xB6, response held while rsp_ready low
        gate_mode = 1;
        send(8'hB6);
        wait_rsp(40, cyc);
        check("t2_lat", 16'(cyc), 16'd6);
        check("t2_rsp", {6'd0, rsp_result, rsp_seg}, {6'd0, 2'b01, 8'hC1});
        for (int i = 0; i < 10; i++) tick();
        check("t2_hold", {5'd0, rsp_valid, rsp_result, key_out}, {5'd0, 1'b1, 2'b01, 8'hB6});
        handshake();

        // Alternating gate times out after 64 sample cycles
        gate_mode = 2;
        send(8'h11);
        wait_rsp(200, cyc);
        check("t3_lat", 16'(cyc), 16'd68);
        check("t3_res", {14'd0, rsp_result}, 16'd3);
        handshake();

        // Disabled gate -> FAULT with seg 0xFF
        gate_mode = 3;
        send(8'h22);
        wait_rsp(40, cyc);
        check("t3b_rsp", {6'd0, rsp_result, rsp_seg}, {6'd0, 2'b11, 8'hFF});
        handshake();

        // Bricked gate
        gate_mode = 4;
        send(8'h44);
        wait_rsp(40, cyc);
        check("t4_rsp", {6'd0, rsp_result, rsp_seg}, {6'd0, 2'b10, 8'h00});
        handshake();

        // Reset mid-SETTLE drops the transaction
        send(8'h33);
        tick();
        rst = 1'b1;
        #1;
        check("t4_rst", {key_out, 5'd0, rsp_valid, req_ready, busy}, {8'h00, 5'd0, 1'b0, 1'b1, 1'b0});
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t4_norsp", {14'd0, rsp_valid, busy}, 16'd0);

        // Back-to-back with req_valid held; request changed while busy
        gate_mode = 0;
        rsp_ready = 1'b1;
        req_key   = 8'h21;
        req_valid = 1'b1;
        tick();
        req_key = 8'h99;
        tick(); tick(); tick();
        check("t5_busy_key", {8'd0, key_out}, 16'h0021);
        tick(); tick(); tick();
        check("t5_rsp", {14'd0, rsp_valid, busy}, 16'h0003);
        check("t5_key6", {8'd0, key_out}, 16'h0021);
        tick();
        check("t5_gap", {key_out, 6'd0, rsp_valid, req_ready}, {8'h00, 6'd0, 1'b0, 1'b1});
        tick();
        check("t5_next", {key_out, 7'd0, busy}, {8'h99, 7'd0, 1'b1});
        req_valid = 1'b0;
        wait_rsp(40, cyc);
        tick();
        rsp_ready = 1'b0;
        check("t5_end", {8'd0, key_out}, 16'h0000);

`ifdef SENTINEL_PRESENTER_SWEEP_EN
        // Sweep finds key 0x07
        gate_mode = 5;
        tick();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        tick();
        check("s1_rdy", {15'd0, req_ready}, 16'd0);
        cyc = 0;
        while (!sweep_done && cyc < 500) begin tick(); cyc++; end
        check("s1_done", {7'd0, sweep_done, sweep_found, found_key[6:0]}, {7'd0, 1'b1, 1'b1, 7'h07});
        check("s1_fkey", {8'd0, found_key}, 16'h0007);

        // Gate never unlocks: full sweep ends without success
        gate_mode = 0;
        tick();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        check("s2_clr", {14'd0, sweep_done, sweep_found}, 16'd0);
        cyc = 0;
        while (!sweep_done && cyc < 3000) begin tick(); cyc++; end
        check("s2_done", {12'd0, sweep_done, sweep_found, rsp_valid, req_ready}, 16'b1001);
        check("s2_key", {found_key, key_out}, 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sentinel_key_presenter.md
Name: sentinel_key_presenter

Overview:
- Initiator-side counterpart of the Sentinel lock gate: presents an 8-bit authorization key on the gate's key lines and samples the gate's 7-segment and status-array outputs.
- Decodes the gate's response into a 2-bit result and returns it over a valid/ready handshake.
- Used on the bring-up/test board and in the system bench to exercise the perimeter gate.

Parameters:
- SETTLE_CYCLES, 4: cycles the key is held after being driven before sampling starts (1..255).
- CONFIRM_SAMPLES, 2: consecutive identical {seg, glow} samples required to accept a response (1..15).
- TIMEOUT_CYCLES, 64: sample cycles allowed without confirmation before reporting FAULT (CONFIRM_SAMPLES..1023).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  key request valid
- req_key  in  8  key to present
- req_ready  out  1  presenter can accept a request
- key_out  out  8  drives gate key lines (gate ui_in)
- seg_in  in  8  gate 7-segment output (active-low, {dp,g,f,e,d,c,b,a})
- glow_in  in  8  gate status-array output
- rsp_valid  out  1  result valid
- rsp_result  out  2  00 LOCKED, 01 VERIFIED, 10 BRICKED, 11 FAULT
- rsp_seg  out  8  confirmed seg_in value (last sample on timeout)
- rsp_ready  in  1  consumer accepts result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous and active-high. Outputs on reset: key_out=0x00, req_ready=1, rsp_valid=0, rsp_result=00, rsp_seg=0x00, busy=0. Counters clear and the FSM enters IDLE. Asserting reset mid-transaction drops the transaction without producing a response.
- All outputs are registered.
- IDLE: req_ready=1. A request is accepted on a cycle where req_valid && req_ready. On acceptance:
  - key_out <= req_key on the next edge;
  - req_ready falls on the next edge;
  - the FSM moves to SETTLE.
- SETTLE: key_out held. Counts SETTLE_CYCLES cycles, then moves to SAMPLE.
- SAMPLE: key_out held. Each cycle:
  - Register {seg_in, glow_in}.
  - If the sample equals the previous sample, increment the match count; otherwise the match count becomes 1.
  - When the match count reaches CONFIRM_SAMPLES, classify the sample and go to RESP.
  - If TIMEOUT_CYCLES sample cycles elapse first, go to RESP with FAULT.
- Classification of the confirmed sample:
  - seg 0xC7 and glow 0x00 -> LOCKED.
  - seg 0xC1 and glow 0xFF -> VERIFIED.
  - seg 0x00 and glow 0x00 -> BRICKED.
  - Anything else -> FAULT. This includes seg 0xFF (gate disabled) and seg/glow disagreement.
- RESP: rsp_valid=1. rsp_result and rsp_seg are stable until the handshake.
  - On rsp_valid && rsp_ready: rsp_valid falls, key_out returns to 0x00, and the FSM goes to IDLE. req_ready rises on the same edge.
  - Back-to-back transactions are therefore separated by at least one cycle with key_out=0x00.
- key_out changes only on request acceptance and on response handshake; it never toggles during SETTLE or SAMPLE.
- req_valid arriving while busy is ignored, since req_ready=0. The requester must hold req_valid until it is accepted.
- Latency from acceptance to rsp_valid is 1 + SETTLE_CYCLES + CONFIRM_SAMPLES cycles minimum with a stable gate.
- Counters saturate. The timeout counter is wide enough for TIMEOUT_CYCLES with no wrap.

Optional Feature:
- Macro: SENTINEL_PRESENTER_SWEEP_EN.
- Defined, this adds:
  - input sweep_start (1 bit);
  - outputs sweep_done (1 bit), sweep_found (1 bit) and found_key (8 bits), all reset to 0.
- A one-cycle sweep_start pulse while in IDLE runs internal transactions for keys 0x00, 0x01, ... 0xFF, using the same SETTLE/SAMPLE/blank sequence and no external handshake.
- The sweep stops at the first VERIFIED result: found_key = that key, sweep_found=1, sweep_done=1.
- The sweep also stops on BRICKED or FAULT (sweep_found=0, sweep_done=1, rsp_result reported via rsp_valid), or after 0xFF without success.
- sweep_done stays high until the next sweep_start. req_ready=0 for the whole sweep. A sweep_start that arrives while busy is ignored.
- Undefined: the ports are absent and behaviour is exactly as above.

Test Plan:
- Stable gate model (seg=0xC7, glow=0x00), request key 0x5A -> key_out=0x5A within 1 cycle; rsp_valid after 1+4+2=7 cycles; rsp_result=00, rsp_seg=0xC7; key_out=0x00 after handshake.
- Gate model unlocking on 0xB6 -> rsp_result=01, rsp_seg=0xC1. Hold rsp_ready=0 for 10 cycles -> rsp_valid/result/key_out all held stable.
- Gate seg alternating 0xC7/0xC1 every cycle -> FAULT (11) after exactly TIMEOUT_CYCLES=64 sample cycles. Gate seg=0xFF stable -> FAULT.
- Gate bricked (seg=0x00, glow=0x00) -> BRICKED (10). Then assert rst mid-SETTLE -> key_out=0x00, rsp_valid=0, req_ready=1 immediately, with no response emitted.
- req_valid held high with rsp_ready=1 continuously -> key_out shows a 0x00 gap of at least 1 cycle between transactions; req_valid while busy is not accepted.
- SWEEP_EN build, gate key 0x07 -> sweep_done=1, sweep_found=1, found_key=0x07 after 8 transactions. Gate that never unlocks -> sweep_found=0 after key 0xFF.
